// File: rtl/cpu_pkg.sv
// Shared types and encodings for the 16-bit RISC sequencing controller.
// States, opcode fields, datapath select codes and instruction classes.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WB,
    S_WB_IMM,
    S_ADDR,
    S_LATCH_DA,
    S_MEM_RD,
    S_WB_MEM,
    S_GET_RD,
    S_PASS,
    S_MEM_WR,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ILL,
    C_MOVI,
    C_MOVR,
    C_MVN,
    C_ADD,
    C_CMP,
    C_AND,
    C_LDR,
    C_STR,
    C_HALT,
    C_BR
  } iclass_t;

  localparam logic [2:0] OPC_BR   = 3'b001;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;
  localparam logic [1:0] OP_IMM = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] WBS_C   = 2'b00;
  localparam logic [1:0] WBS_PC  = 2'b01;
  localparam logic [1:0] WBS_IMM = 2'b10;
  localparam logic [1:0] WBS_MEM = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

endpackage

// File: rtl/cpu_controller_decoder.sv
// Combinational IR field split, immediate sign-extension, class decode.
// Branch class exists only when CPU_CTRL_BRANCH_EN is defined.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  op,
  output logic [1:0]  sh,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output iclass_t     cls
);

  logic [2:0] opc;

  assign opc    = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  // classify the instruction; anything unmatched is illegal
  always_comb begin
    cls = C_ILL;
    unique case (1'b1)
      opc == OPC_MOV && op == OP_IMM: cls = C_MOVI;
      opc == OPC_MOV && op == 2'b00:  cls = C_MOVR;
      opc == OPC_ALU && op == OP_ADD: cls = C_ADD;
      opc == OPC_ALU && op == OP_CMP: cls = C_CMP;
      opc == OPC_ALU && op == OP_AND: cls = C_AND;
      opc == OPC_ALU && op == OP_MVN: cls = C_MVN;
      opc == OPC_LDR && op == 2'b00:  cls = C_LDR;
      opc == OPC_STR && op == 2'b00:  cls = C_STR;
      opc == OPC_HALT:                cls = C_HALT;
`ifdef CPU_CTRL_BRANCH_EN
      opc == OPC_BR && rn <= 3'd4:    cls = C_BR;
`endif
      default:                        cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Moore sequencer: fetch, decode, datapath control, PC and data address.
// Define CPU_CTRL_BRANCH_EN to enable opcode 001 conditional branches.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mdata,
  input  logic        mem_ready,
  input  logic [15:0] dp_out,
  input  logic        Z_in,
  input  logic        N_in,
  input  logic        V_in,
  output logic [1:0]  mem_cmd,
  output logic [7:0]  mem_addr,
  output logic [7:0]  pc,
  output logic [1:0]  wb_sel,
  output logic [1:0]  shift_op,
  output logic [1:0]  ALU_op,
  output logic [2:0]  w_addr,
  output logic [2:0]  r_addr,
  output logic        w_en,
  output logic        en_A,
  output logic        en_B,
  output logic        en_C,
  output logic        en_status,
  output logic        sel_A,
  output logic        sel_B,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        halted,
  output logic        illegal
);

  state_t      state, nxt;
  logic [15:0] ir;
  logic [7:0]  pc_q;
  logic [7:0]  da;
  logic        ill;
  logic [2:0]  rn, rd, rm;
  logic [1:0]  op, sh;
  iclass_t     cls;
  logic        unused_dp;

  instr_decoder u_dec (
    .ir     (ir),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .op     (op),
    .sh     (sh),
    .sximm5 (sximm5),
    .sximm8 (sximm8),
    .cls    (cls)
  );

  assign pc        = pc_q;
  assign halted    = (state == S_HALT);
  assign illegal   = ill;
  assign unused_dp = ^dp_out[15:8];

`ifdef CPU_CTRL_BRANCH_EN
  logic br_take;

  // branch condition from the datapath status register
  always_comb begin
    br_take = 1'b0;
    unique case (rn)
      3'd0:    br_take = 1'b1;
      3'd1:    br_take = Z_in;
      3'd2:    br_take = !Z_in;
      3'd3:    br_take = N_in != V_in;
      3'd4:    br_take = (N_in != V_in) || Z_in;
      default: br_take = 1'b0;
    endcase
  end
`else
  logic unused_flags;
  assign unused_flags = ^{Z_in, N_in, V_in};
`endif

  // state, IR, PC, data address and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc_q  <= RESET_PC;
      ir    <= '0;
      da    <= '0;
      ill   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_FETCH && mem_ready) begin
        ir   <= mdata;
        pc_q <= pc_q + 8'd1;
      end
      if (state == S_LATCH_DA)
        da <= dp_out[7:0];
      if (state == S_DECODE && cls == C_ILL)
        ill <= 1'b1;
`ifdef CPU_CTRL_BRANCH_EN
      if (state == S_DECODE && cls == C_BR && br_take)
        pc_q <= pc_q + sximm8[7:0];
`endif
    end
  end

  // next state and Moore control outputs
  always_comb begin
    nxt       = state;
    mem_cmd   = MEM_NONE;
    mem_addr  = pc_q;
    wb_sel    = WBS_C;
    shift_op  = 2'b00;
    ALU_op    = ALU_ADD;
    w_addr    = 3'd0;
    r_addr    = 3'd0;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_cmd = rst_n ? MEM_READ : MEM_NONE;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        unique case (cls)
          C_MOVI:        nxt = S_WB_IMM;
          C_MOVR, C_MVN: nxt = S_GET_B;
          C_ADD, C_CMP,
          C_AND, C_LDR,
          C_STR:         nxt = S_GET_A;
          C_BR:          nxt = S_FETCH;
          default:       nxt = S_HALT;
        endcase
      end
      S_GET_A: begin
        r_addr = rn;
        en_A   = 1'b1;
        nxt    = (cls == C_LDR || cls == C_STR) ? S_ADDR : S_GET_B;
      end
      S_GET_B: begin
        r_addr = rm;
        en_B   = 1'b1;
        nxt    = S_EXEC;
      end
      S_EXEC: begin
        shift_op = sh;
        sel_A    = (cls == C_MOVR || cls == C_MVN);
        ALU_op   = (cls == C_MOVR) ? ALU_ADD : op;
        if (cls == C_CMP) begin
          en_status = 1'b1;
          nxt       = S_FETCH;
        end else begin
          en_C = 1'b1;
          nxt  = S_WB;
        end
      end
      S_WB: begin
        w_addr = rd;
        w_en   = 1'b1;
        nxt    = S_FETCH;
      end
      S_WB_IMM: begin
        w_addr = rn;
        wb_sel = WBS_IMM;
        w_en   = 1'b1;
        nxt    = S_FETCH;
      end
      S_ADDR: begin
        sel_B = 1'b1;
        en_C  = 1'b1;
        nxt   = S_LATCH_DA;
      end
      S_LATCH_DA: nxt = (cls == C_LDR) ? S_MEM_RD : S_GET_RD;
      S_MEM_RD: begin
        mem_cmd  = MEM_READ;
        mem_addr = da;
        if (mem_ready) nxt = S_WB_MEM;
      end
      S_WB_MEM: begin
        w_addr = rd;
        wb_sel = WBS_MEM;
        w_en   = 1'b1;
        nxt    = S_FETCH;
      end
      S_GET_RD: begin
        r_addr = rd;
        en_B   = 1'b1;
        nxt    = S_PASS;
      end
      S_PASS: begin
        sel_A = 1'b1;
        en_C  = 1'b1;
        nxt   = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_cmd  = MEM_WRITE;
        mem_addr = da;
        if (mem_ready) nxt = S_FETCH;
      end
      S_HALT:  nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: per-cycle expected control snapshots.
// Branch vectors run only when CPU_CTRL_BRANCH_EN is defined.
module tb_cpu_controller;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [7:0]  addr;
    logic        ea;
    logic        eb;
    logic [2:0]  ra;
    logic        ec;
    logic        es;
    logic        sa;
    logic        sb;
    logic [1:0]  alu;
    logic [1:0]  sh;
    logic [15:0] imm;
    logic        we;
    logic [2:0]  wa;
    logic [1:0]  wb;
    logic [7:0]  pc;
    logic        hl;
    logic        il;
  } snap_t;

  logic        clk, rst_n;
  logic [15:0] mdata, dp_out;
  logic        mem_ready, Z_in, N_in, V_in;
  logic [1:0]  mem_cmd, wb_sel, shift_op, ALU_op;
  logic [7:0]  mem_addr, pc;
  logic [2:0]  w_addr, r_addr;
  logic        w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
  logic [15:0] sximm8, sximm5;
  logic        halted, illegal;

  logic [15:0] mem [256];
  int          rd_wait, wr_wait, need, wait_cnt;
  logic [7:0]  slow_addr;
  snap_t       exp_q[$];
  string       tag_q[$];
  int          n_cmp, n_bad;

  cpu_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mdata     (mdata),
    .mem_ready (mem_ready),
    .dp_out    (dp_out),
    .Z_in      (Z_in),
    .N_in      (N_in),
    .V_in      (V_in),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .pc        (pc),
    .wb_sel    (wb_sel),
    .shift_op  (shift_op),
    .ALU_op    (ALU_op),
    .w_addr    (w_addr),
    .r_addr    (r_addr),
    .w_en      (w_en),
    .en_A      (en_A),
    .en_B      (en_B),
    .en_C      (en_C),
    .en_status (en_status),
    .sel_A     (sel_A),
    .sel_B     (sel_B),
    .sximm8    (sximm8),
    .sximm5    (sximm5),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mdata  = mem[mem_addr];
  assign dp_out = {8'hA5, pc + 8'h40};
  assign need   = (mem_cmd == 2'b01 && mem_addr == slow_addr) ? rd_wait :
                  (mem_cmd == 2'b10) ? wr_wait : 0;
  assign mem_ready = (wait_cnt >= need);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (mem_cmd != 2'b00 && !mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // monitor: snapshot the active controls each cycle and check the queue
  always @(negedge clk) begin
    snap_t a, e;
    string t;
    a = '0;
    if (mem_cmd != 2'b00) begin
      a.cmd  = mem_cmd;
      a.addr = mem_addr;
    end
    if (en_A || en_B) begin
      a.ea = en_A;
      a.eb = en_B;
      a.ra = r_addr;
    end
    if (en_C || en_status) begin
      a.ec  = en_C;
      a.es  = en_status;
      a.sa  = sel_A;
      a.sb  = sel_B;
      a.alu = ALU_op;
      if (sel_B) a.imm = sximm5;
      else a.sh = shift_op;
    end
    if (w_en) begin
      a.we = 1'b1;
      a.wa = w_addr;
      a.wb = wb_sel;
      if (wb_sel == 2'b10) a.imm = sximm8;
    end
    a.pc = pc;
    a.hl = halted;
    a.il = illegal;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", t, a, e);
      end
    end
  end

  task automatic push(input snap_t s, input string t);
    exp_q.push_back(s);
    tag_q.push_back(t);
  endtask

  function automatic snap_t base(input logic [7:0] p);
    snap_t s;
    s = '0;
    s.pc = p;
    return s;
  endfunction

  task automatic e_idle(input logic [7:0] p, input string t);
    push(base(p), t);
  endtask

  task automatic e_fetch(input logic [7:0] p, input int n);
    snap_t s;
    s = base(p);
    s.cmd = 2'b01;
    s.addr = p;
    for (int i = 0; i < n; i++) push(s, "fetch");
  endtask

  task automatic e_reg(input logic [7:0] p, input logic b,
                       input logic [2:0] r, input string t);
    snap_t s;
    s = base(p);
    s.ea = !b;
    s.eb = b;
    s.ra = r;
    push(s, t);
  endtask

  task automatic e_alu(input logic [7:0] p, input logic es,
                       input logic sa, input logic sb,
                       input logic [1:0] alu, input logic [1:0] sh,
                       input logic [15:0] imm, input string t);
    snap_t s;
    s = base(p);
    s.ec = !es;
    s.es = es;
    s.sa = sa;
    s.sb = sb;
    s.alu = alu;
    if (sb) s.imm = imm;
    else s.sh = sh;
    push(s, t);
  endtask

  task automatic e_wb(input logic [7:0] p, input logic [2:0] wa,
                      input logic [1:0] wb, input logic [15:0] imm,
                      input string t);
    snap_t s;
    s = base(p);
    s.we = 1'b1;
    s.wa = wa;
    s.wb = wb;
    s.imm = imm;
    push(s, t);
  endtask

  task automatic e_mem(input logic [7:0] p, input logic [1:0] c,
                       input logic [7:0] ad, input int n, input string t);
    snap_t s;
    s = base(p);
    s.cmd = c;
    s.addr = ad;
    for (int i = 0; i < n; i++) push(s, t);
  endtask

  task automatic e_halt(input logic [7:0] p, input logic il, input int n);
    snap_t s;
    s = base(p);
    s.hl = 1'b1;
    s.il = il;
    for (int i = 0; i < n; i++) push(s, "halt");
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push(base(8'h00), "reset");
    drain(5);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    Z_in = 1'b0;
    N_in = 1'b0;
    V_in = 1'b0;
    rd_wait = 3;
    wr_wait = 0;
    slow_addr = 8'h47;
    clear_mem();
    mem[0] = 16'hD0FD;
    mem[1] = 16'hA148;
    mem[2] = 16'hB864;
    mem[3] = 16'hC022;
    mem[4] = 16'hAD16;
    mem[5] = 16'hB586;
    mem[6] = 16'h61E2;
    mem[7] = 16'h82DF;
    mem[8] = 16'hE000;
    #1 rst_n = 1'b0;
    push(base(8'h00), "reset");
    drain(5);

    release_rst();
    e_fetch(8'h00, 1);
    e_idle(8'h01, "dec movi");
    e_wb(8'h01, 3'd0, 2'b10, 16'hFFFD, "wb movi");
    e_fetch(8'h01, 1);
    e_idle(8'h02, "dec add");
    e_reg(8'h02, 1'b0, 3'd1, "geta add");
    e_reg(8'h02, 1'b1, 3'd0, "getb add");
    e_alu(8'h02, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 16'h0, "exec add");
    e_wb(8'h02, 3'd2, 2'b00, 16'h0, "wb add");
    e_fetch(8'h02, 1);
    e_idle(8'h03, "dec mvn");
    e_reg(8'h03, 1'b1, 3'd4, "getb mvn");
    e_alu(8'h03, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 16'h0, "exec mvn");
    e_wb(8'h03, 3'd3, 2'b00, 16'h0, "wb mvn");
    e_fetch(8'h03, 1);
    e_idle(8'h04, "dec mov");
    e_reg(8'h04, 1'b1, 3'd2, "getb mov");
    e_alu(8'h04, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 16'h0, "exec mov");
    e_wb(8'h04, 3'd1, 2'b00, 16'h0, "wb mov");
    e_fetch(8'h04, 1);
    e_idle(8'h05, "dec cmp");
    e_reg(8'h05, 1'b0, 3'd5, "geta cmp");
    e_reg(8'h05, 1'b1, 3'd6, "getb cmp");
    e_alu(8'h05, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 16'h0, "exec cmp");
    e_fetch(8'h05, 1);
    e_idle(8'h06, "dec and");
    e_reg(8'h06, 1'b0, 3'd5, "geta and");
    e_reg(8'h06, 1'b1, 3'd6, "getb and");
    e_alu(8'h06, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 16'h0, "exec and");
    e_wb(8'h06, 3'd4, 2'b00, 16'h0, "wb and");
    e_fetch(8'h06, 1);
    e_idle(8'h07, "dec ldr");
    e_reg(8'h07, 1'b0, 3'd1, "geta ldr");
    e_alu(8'h07, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 16'h0002, "addr ldr");
    e_idle(8'h07, "latch ldr");
    e_mem(8'h07, 2'b01, 8'h47, 4, "memrd ldr");
    e_wb(8'h07, 3'd7, 2'b11, 16'h0, "wb ldr");
    e_fetch(8'h07, 1);
    e_idle(8'h08, "dec str");
    e_reg(8'h08, 1'b0, 3'd2, "geta str");
    e_alu(8'h08, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 16'hFFFF, "addr str");
    e_idle(8'h08, "latch str");
    e_reg(8'h08, 1'b1, 3'd6, "getrd str");
    e_alu(8'h08, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 16'h0, "pass str");
    e_mem(8'h08, 2'b10, 8'h48, 1, "memwr str");
    e_fetch(8'h08, 1);
    e_idle(8'h09, "dec halt");
    e_halt(8'h09, 1'b0, 3);
    drain(200);

    do_reset();
    clear_mem();
    mem[0] = 16'h82DF;
    wr_wait = 200;
    release_rst();
    e_fetch(8'h00, 1);
    e_idle(8'h01, "dec str2");
    e_reg(8'h01, 1'b0, 3'd2, "geta str2");
    e_alu(8'h01, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 16'hFFFF, "addr str2");
    e_idle(8'h01, "latch str2");
    e_reg(8'h01, 1'b1, 3'd6, "getrd str2");
    e_alu(8'h01, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 16'h0, "pass str2");
    e_mem(8'h01, 2'b10, 8'h41, 3, "memwr stall");
    drain(50);
    do_reset();

    clear_mem();
    mem[0] = 16'h0000;
    wr_wait = 0;
    slow_addr = 8'h00;
    rd_wait = 2;
    release_rst();
    e_fetch(8'h00, 3);
    e_idle(8'h01, "dec op000");
    e_halt(8'h01, 1'b1, 2);
    drain(50);
    do_reset();

    slow_addr = 8'h47;
    rd_wait = 0;
`ifdef CPU_CTRL_BRANCH_EN
    clear_mem();
    mem[0] = 16'h2500;
    release_rst();
    e_fetch(8'h00, 1);
    e_idle(8'h01, "dec badcond");
    e_halt(8'h01, 1'b1, 2);
    drain(50);
    do_reset();

    for (int z = 1; z >= 0; z--) begin
      clear_mem();
      mem[8'h00] = 16'h20FC;
      mem[8'hFD] = 16'hAD16;
      mem[8'hFE] = 16'h2103;
      Z_in = z[0];
      release_rst();
      e_fetch(8'h00, 1);
      e_idle(8'h01, "dec b");
      e_fetch(8'hFD, 1);
      e_idle(8'hFE, "dec cmp");
      e_reg(8'hFE, 1'b0, 3'd5, "geta cmp");
      e_reg(8'hFE, 1'b1, 3'd6, "getb cmp");
      e_alu(8'hFE, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 16'h0, "exec cmp");
      e_fetch(8'hFE, 1);
      e_idle(8'hFF, "dec beq");
      if (z == 1) begin
        e_fetch(8'h02, 1);
        e_idle(8'h03, "dec halt");
        e_halt(8'h03, 1'b0, 2);
      end else begin
        e_fetch(8'hFF, 1);
        e_idle(8'h00, "dec halt");
        e_halt(8'h00, 1'b0, 2);
      end
      drain(60);
      do_reset();
    end
`else
    clear_mem();
    mem[0] = 16'h2103;
    release_rst();
    e_fetch(8'h00, 1);
    e_idle(8'h01, "dec op001");
    e_halt(8'h01, 1'b1, 2);
    drain(50);
    do_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
